// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the in-order RISC-V pipeline.
//   operation_e : decoded operation carried down the pipe
//   is_load()   : true for the variable-latency load operations
//   fwd_sel_t   : operand-mux select, 0 = register file, k = producer stage k-1
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [5:0] {
        OP_NOP,
        OP_LUI,  OP_AUIPC, OP_JAL,  OP_JALR,
        OP_BEQ,  OP_BNE,   OP_BLT,  OP_BGE,  OP_BLTU, OP_BGEU,
        OP_LB,   OP_LH,    OP_LW,   OP_LBU,  OP_LHU,
        OP_SB,   OP_SH,    OP_SW,
        OP_ADDI, OP_SLTI,  OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI,  OP_SRAI,
        OP_ADD,  OP_SUB,   OP_SLL,  OP_SLT,  OP_SLTU, OP_XOR,
        OP_SRL,  OP_SRA,   OP_OR,   OP_AND
    } operation_e;

    // Forward selects are sized for the deepest supported network so the
    // type stays fixed across pipeline variants (NUM_FWD_STAGES <= 7).
    localparam int unsigned FWD_STAGES_MAX = 7;
    localparam int unsigned FWD_SEL_W      = $clog2(FWD_STAGES_MAX + 1);

    typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = '0;

    // Width of the flush down-counter (FLUSH_CYCLES limited to 1..7).
    localparam int unsigned FCNT_W = 3;

    function automatic logic is_load(operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_prio_sel.sv
// -----------------------------------------------------------------------------
// fwd_prio_sel
// Per-operand forwarding priority encoder over NUM_STAGES producer stages.
//   rs_i       : source register read in decode
//   rd_stage_i : destination per producer stage, stage k at [k*REG_AW +: REG_AW]
//   wr_en_i    : write-enable per producer stage
//   sel_o      : 0 = register file, k = stage k-1 (youngest match wins)
// -----------------------------------------------------------------------------
module fwd_prio_sel
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned REG_AW     = 5
) (
    input  logic [REG_AW-1:0]            rs_i,
    input  logic [NUM_STAGES*REG_AW-1:0] rd_stage_i,
    input  logic [NUM_STAGES-1:0]        wr_en_i,
    output fwd_sel_t                     sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        // x0 is never forwarded; rd == rs with rs != 0 also excludes rd == 0.
        if (rs_i != '0) begin
            // Scan oldest to youngest so the youngest match is written last.
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (wr_en_i[NUM_STAGES-1-i] &&
                    rd_stage_i[(NUM_STAGES-1-i)*REG_AW +: REG_AW] == rs_i) begin
                    sel_o = fwd_sel_t'(NUM_STAGES - i);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller beside the decode stage: forwarding selects, load-use and
// scoreboard stalls for variable-latency loads, branch flush sequencing and a
// stall performance counter.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   rs1D_i/rs2D_i, rs*_used_i  : decode source registers and their use flags
//   rd_stage_i, wr_en_stage_i  : producer stages, stage 0 = EX (youngest)
//   opE_i, branch_tkn_i        : operation in EX, branch resolved taken in EX
//   mem_wait_i                 : data memory not ready, whole pipe frozen
//   ld_rvalid_i, ld_rd_i       : load data return and its destination
//   pc_en_o, stall_o, flush_o  : PC enable, IF/ID hold, younger-stage squash
//   forwardA_o, forwardB_o     : operand-mux selects
//   pending_o                  : scoreboard, one bit per register
//   stall_cnt_o                : saturating count of stall/mem-wait cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [REG_AW-1:0]                   rs1D_i,
    input  logic [REG_AW-1:0]                   rs2D_i,
    input  logic                                rs1_used_i,
    input  logic                                rs2_used_i,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0]    rd_stage_i,
    input  logic [NUM_FWD_STAGES-1:0]           wr_en_stage_i,
    input  operation_e                          opE_i,
    input  logic                                branch_tkn_i,
    input  logic                                mem_wait_i,
    input  logic                                ld_rvalid_i,
    input  logic [REG_AW-1:0]                   ld_rd_i,
    output logic                                pc_en_o,
    output logic                                stall_o,
    output logic                                flush_o,
    output fwd_sel_t                            forwardA_o,
    output fwd_sel_t                            forwardB_o,
    output logic [2**REG_AW-1:0]                pending_o,
    output logic [CNT_W-1:0]                    stall_cnt_o
);

    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    logic [2**REG_AW-1:0] pending_q, pending_d;
    logic [FCNT_W-1:0]    fcnt_q;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [REG_AW-1:0]    rd_e;
    logic                 load_e, lu1, lu2, hazard, branch_acc;

    fwd_prio_sel #(.NUM_STAGES(NUM_FWD_STAGES), .REG_AW(REG_AW)) u_fwd_a (
        .rs_i       (rs1D_i),
        .rd_stage_i (rd_stage_i),
        .wr_en_i    (wr_en_stage_i),
        .sel_o      (forwardA_o)
    );

    fwd_prio_sel #(.NUM_STAGES(NUM_FWD_STAGES), .REG_AW(REG_AW)) u_fwd_b (
        .rs_i       (rs2D_i),
        .rd_stage_i (rd_stage_i),
        .wr_en_i    (wr_en_stage_i),
        .sel_o      (forwardB_o)
    );

    assign rd_e       = rd_stage_i[REG_AW-1:0];
    assign load_e     = is_load(opE_i);
    assign lu1        = load_e && (rd_e == rs1D_i);
    assign lu2        = load_e && (rd_e == rs2D_i);
    assign hazard     = (rs1_used_i && (rs1D_i != '0) && (pending_q[rs1D_i] || lu1)) ||
                        (rs2_used_i && (rs2D_i != '0) && (pending_q[rs2D_i] || lu2));
    assign branch_acc = branch_tkn_i && !mem_wait_i;

    assign flush_o     = branch_acc || (fcnt_q != '0);
    assign stall_o     = hazard && !flush_o;
    assign pc_en_o     = !(stall_o || mem_wait_i);
    assign pending_o   = pending_q;
    assign stall_cnt_o = stall_cnt_q;

    // Set is applied after clear so a load leaving EX wins over a same-register
    // return. A load-use stall only bubbles the consumer; the load itself still
    // leaves EX, so stall_o does not block the set.
    always_comb begin
        pending_d = pending_q;
        if (ld_rvalid_i) begin
            pending_d[ld_rd_i] = 1'b0;
        end
        if (load_e && (rd_e != '0) && !mem_wait_i && !flush_o) begin
            pending_d[rd_e] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;

            if (branch_acc) begin
                fcnt_q <= FCNT_RELOAD;
            end else if ((fcnt_q != '0) && !mem_wait_i) begin
                fcnt_q <= fcnt_q - 1'b1;
            end

            if ((stall_o || mem_wait_i) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl with NUM_FWD_STAGES=3, FLUSH_CYCLES=3,
// CNT_W=4: a table of combinational vectors plus hand-written sequences for
// the scoreboard, flush sequencer, reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import riscv_pkg::*;

    localparam int unsigned NFS = 3;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     rs1D_i, rs2D_i, ld_rd_i;
    logic              rs1_used_i, rs2_used_i;
    logic [NFS*AW-1:0] rd_stage_i;
    logic [NFS-1:0]    wr_en_stage_i;
    operation_e        opE_i;
    logic              branch_tkn_i, mem_wait_i, ld_rvalid_i;
    logic              pc_en_o, stall_o, flush_o;
    fwd_sel_t          forwardA_o, forwardB_o;
    logic [2**AW-1:0]  pending_o;
    logic [CW-1:0]     stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NUM_FWD_STAGES (NFS),
        .REG_AW         (AW),
        .FLUSH_CYCLES   (3),
        .CNT_W          (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .rs1D_i        (rs1D_i),
        .rs2D_i        (rs2D_i),
        .rs1_used_i    (rs1_used_i),
        .rs2_used_i    (rs2_used_i),
        .rd_stage_i    (rd_stage_i),
        .wr_en_stage_i (wr_en_stage_i),
        .opE_i         (opE_i),
        .branch_tkn_i  (branch_tkn_i),
        .mem_wait_i    (mem_wait_i),
        .ld_rvalid_i   (ld_rvalid_i),
        .ld_rd_i       (ld_rd_i),
        .pc_en_o       (pc_en_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .forwardA_o    (forwardA_o),
        .forwardB_o    (forwardB_o),
        .pending_o     (pending_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd0, rd1, rd2;
        logic [2:0] wen;
        operation_e op;
        logic       br, mw;
        logic [2:0] fa, fb;
        logic       st, fl, pc;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1D_i = '0; rs2D_i = '0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
        rd_stage_i = '0; wr_en_stage_i = '0; opE_i = OP_ADD;
        branch_tkn_i = 1'b0; mem_wait_i = 1'b0; ld_rvalid_i = 1'b0; ld_rd_i = '0;
    endtask

    task automatic load_in_ex(input operation_e op, input logic [4:0] rd);
        opE_i = op;
        rd_stage_i = {10'd0, rd};
        wr_en_stage_i = 3'b001;
    endtask

    task automatic run_flush(input string name, input logic [5:0] br, input logic [5:0] mw,
                             input logic [5:0] exp);
        logic [5:0] seen;
        seen = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            branch_tkn_i = br[i];
            mem_wait_i   = mw[i];
            @(negedge clk);
            seen[i] = flush_o;
            step();
        end
        idle();
        check(name, 32'(seen), 32'(exp));
    endtask

    initial begin
        //                rs1  rs2  u1 u2 rd0  rd1  rd2  wen     op       br mw  fa fb st fl pc
        tbl[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 3'b000, OP_ADD, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{5'd5, 5'd0, 1, 0, 5'd5, 5'd0, 5'd5, 3'b101, OP_ADD, 0, 0, 1, 0, 0, 0, 1};
        tbl[2]  = '{5'd5, 5'd0, 1, 0, 5'd5, 5'd0, 5'd5, 3'b100, OP_ADD, 0, 0, 3, 0, 0, 0, 1};
        tbl[3]  = '{5'd0, 5'd0, 1, 0, 5'd0, 5'd0, 5'd0, 3'b001, OP_ADD, 0, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{5'd5, 5'd6, 1, 1, 5'd6, 5'd5, 5'd6, 3'b111, OP_ADD, 0, 0, 2, 1, 0, 0, 1};
        tbl[5]  = '{5'd6, 5'd5, 1, 1, 5'd1, 5'd5, 5'd6, 3'b110, OP_ADD, 0, 0, 3, 2, 0, 0, 1};
        tbl[6]  = '{5'd0, 5'd7, 0, 1, 5'd7, 5'd0, 5'd0, 3'b001, OP_LW,  0, 0, 0, 1, 1, 0, 0};
        tbl[7]  = '{5'd0, 5'd7, 0, 0, 5'd7, 5'd0, 5'd0, 3'b001, OP_LW,  0, 0, 0, 1, 0, 0, 1};
        tbl[8]  = '{5'd0, 5'd0, 1, 0, 5'd0, 5'd0, 5'd0, 3'b001, OP_LW,  0, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{5'd7, 5'd0, 1, 0, 5'd7, 5'd0, 5'd0, 3'b001, OP_LW,  1, 0, 1, 0, 0, 1, 1};
        tbl[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 3'b000, OP_ADD, 0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 3'b000, OP_ADD, 1, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{5'd7, 5'd0, 1, 0, 5'd7, 5'd0, 5'd0, 3'b001, OP_ADD, 0, 0, 1, 0, 0, 0, 1};
        tbl[13] = '{5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 3'b000, OP_LBU, 0, 0, 0, 0, 1, 0, 0};
        tbl[14] = '{5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 3'b000, OP_SW,  0, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{5'd4, 5'd4, 0, 1, 5'd4, 5'd0, 5'd0, 3'b001, OP_LH,  0, 1, 1, 1, 1, 0, 0};
        tbl[16] = '{5'd2, 5'd0, 1, 0, 5'd2, 5'd0, 5'd0, 3'b000, OP_LHU, 0, 0, 0, 0, 1, 0, 0};
        tbl[17] = '{5'd0, 5'd31, 0, 1, 5'd31, 5'd0, 5'd0, 3'b000, OP_LB, 0, 0, 0, 0, 1, 0, 0};

        idle();
        rst_i = 1'b1;
        step();
        step();

        // Vectors are applied with reset held so scoreboard and flush state
        // stay cleared and every output is a pure function of the vector.
        for (int i = 0; i < NVEC; i++) begin
            rs1D_i = tbl[i].rs1; rs2D_i = tbl[i].rs2;
            rs1_used_i = tbl[i].u1; rs2_used_i = tbl[i].u2;
            rd_stage_i = {tbl[i].rd2, tbl[i].rd1, tbl[i].rd0};
            wr_en_stage_i = tbl[i].wen; opE_i = tbl[i].op;
            branch_tkn_i = tbl[i].br; mem_wait_i = tbl[i].mw;
            @(negedge clk);
            check($sformatf("vec%0d_fwdA", i), 32'(forwardA_o), 32'(tbl[i].fa));
            check($sformatf("vec%0d_fwdB", i), 32'(forwardB_o), 32'(tbl[i].fb));
            check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(tbl[i].st));
            check($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(tbl[i].fl));
            check($sformatf("vec%0d_pc_en", i), 32'(pc_en_o), 32'(tbl[i].pc));
            step();
        end

        // Reset state with idle inputs.
        idle();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_pc_en", 32'(pc_en_o), 32'd1);
        check("rst_fwd", 32'({forwardA_o, forwardB_o}), 32'd0);
        step();

        // Load-use on x7, then scoreboard hold until one cycle after rvalid.
        load_in_ex(OP_LW, 5'd7);
        rs2D_i = 5'd7; rs2_used_i = 1'b1;
        @(negedge clk);
        check("lu_stall", 32'(stall_o), 32'd1);
        check("lu_pc_en", 32'(pc_en_o), 32'd0);
        step();
        opE_i = OP_ADD; rd_stage_i = '0; wr_en_stage_i = '0;
        @(negedge clk);
        check("lu_pending7", 32'(pending_o[7]), 32'd1);
        check("lu_stall_c2", 32'(stall_o), 32'd1);
        step();
        ld_rvalid_i = 1'b1; ld_rd_i = 5'd7;
        @(negedge clk);
        check("lu_stall_rvalid", 32'(stall_o), 32'd1);
        step();
        ld_rvalid_i = 1'b0;
        @(negedge clk);
        check("lu_pending_clr", 32'(pending_o), 32'd0);
        check("lu_stall_released", 32'(stall_o), 32'd0);
        check("lu_pc_en_released", 32'(pc_en_o), 32'd1);
        step();

        // Three stall cycles so far; seven mem_wait cycles bring it to 10.
        idle();
        mem_wait_i = 1'b1;
        @(negedge clk);
        check("mw_pc_en", 32'(pc_en_o), 32'd0);
        repeat (7) step();
        mem_wait_i = 1'b0;
        @(negedge clk);
        check("cnt_10", 32'(stall_cnt_o), 32'd10);

        // Load to x0 never sets pending.
        load_in_ex(OP_LW, 5'd0);
        step();
        idle();
        @(negedge clk);
        check("x0_pending", 32'(pending_o), 32'd0);

        // Set/clear collision on x9: set wins; a later clear empties it.
        load_in_ex(OP_LW, 5'd9);
        ld_rvalid_i = 1'b1; ld_rd_i = 5'd9;
        step();
        idle();
        @(negedge clk);
        check("collide_pending9", 32'(pending_o), 32'h0000_0200);
        ld_rvalid_i = 1'b1; ld_rd_i = 5'd9;
        step();
        idle();
        @(negedge clk);
        check("collide_cleared", 32'(pending_o), 32'd0);
        step();

        // Flush sequencing, bit i = cycle i.
        run_flush("flush_len3", 6'b000001, 6'b000000, 6'b000111);
        run_flush("flush_memwait", 6'b000001, 6'b000010, 6'b001111);
        run_flush("flush_restart", 6'b000011, 6'b000000, 6'b001111);

        // Load hazard during flush: flush wins and the squashed load is not scoreboarded.
        load_in_ex(OP_LW, 5'd7);
        rs1D_i = 5'd7; rs1_used_i = 1'b1; branch_tkn_i = 1'b1;
        @(negedge clk);
        check("fl_hz_stall", 32'(stall_o), 32'd0);
        check("fl_hz_flush", 32'(flush_o), 32'd1);
        check("fl_hz_pc_en", 32'(pc_en_o), 32'd1);
        step();
        branch_tkn_i = 1'b0;
        @(negedge clk);
        check("fl_hz_stall_c2", 32'(stall_o), 32'd0);
        step();
        idle();
        step();
        @(negedge clk);
        check("fl_hz_pending", 32'(pending_o), 32'd0);
        check("fl_hz_flush_done", 32'(flush_o), 32'd0);
        step();

        // Reset with x9 pending and fcnt = 2.
        load_in_ex(OP_LW, 5'd9);
        step();
        idle();
        branch_tkn_i = 1'b1;
        @(negedge clk);
        check("pre_rst_pending9", 32'(pending_o[9]), 32'd1);
        step();
        branch_tkn_i = 1'b0;
        @(negedge clk);
        check("pre_rst_flush", 32'(flush_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_pending", 32'(pending_o), 32'd0);
        check("post_rst_flush", 32'(flush_o), 32'd0);
        check("post_rst_cnt", 32'(stall_cnt_o), 32'd0);
        step();

        // Counter saturation at 15 with CNT_W = 4.
        mem_wait_i = 1'b1;
        repeat (14) step();
        @(negedge clk);
        check("cnt_14", 32'(stall_cnt_o), 32'd14);
        step();
        @(negedge clk);
        check("cnt_15", 32'(stall_cnt_o), 32'd15);
        repeat (2) step();
        @(negedge clk);
        check("cnt_sat", 32'(stall_cnt_o), 32'd15);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
